bram_access_ctrl: RTL
=====================

# bram_access_ctrl

- Initiator for the single-port data BRAM wrapper: accepts byte/half/word load and store requests from the CPU memory stage and drives the word-wide BRAM port.
- Extracts and sign/zero-extends load data.
- Since the BRAM port has a single whole-word write enable, implements sub-word stores as read-modify-write.
- Sits between the CPU load/store stage and the BRAM wrapper.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; high only in IDLE and while rstn high.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  loads: zero-extend when 1, sign-extend when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle completion pulse; no backpressure.
- resp_rdata  out  32  extended load data; 0 for stores.
- resp_err  out  1  misaligned/reserved-size request (only with macro, see Configuration).
- mem_we  out  1  to BRAM write enable.
- mem_addr  out  32  to BRAM address; bits [1:0] always 0.
- mem_din  out  32  to BRAM write data.
- mem_dout  in  32  from BRAM; valid the cycle after the address is presented (1-cycle read latency).

## Operation
- States: IDLE, RD, RD_DATA, WR, RESP.
- Handshake: request captured on the edge where req_valid && req_ready. Request fields are latched, so the requester may change them afterwards.
- Load path: IDLE → RD → RD_DATA → RESP → IDLE.
  - RD: mem_addr = {addr[31:2],2'b00}, mem_we = 0.
  - RD_DATA: sample mem_dout, then extract and extend into resp_rdata.
- Word store path: IDLE → WR → RESP → IDLE.
  - WR: mem_we = 1, mem_din = wdata.
- Sub-word store path: IDLE → RD → RD_DATA → WR → RESP → IDLE.
  - RD_DATA: merge wdata lane into the read word.
  - WR: write the merged word.
- Lane selection is little-endian:
  - byte k = bits [8k+7:8k], k = addr[1:0];
  - half = bits [16h+15:16h], h = addr[1].
- Extension: byte/half loads extend to 32 bits per req_unsigned. Word loads are unchanged.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE.
- Registered outputs: resp_rdata and resp_err hold until the next RESP. mem_we is 1 only in WR.
- Addressing: the BRAM decodes addr[11:2] only, so addresses alias modulo 4 KiB. The controller passes upper bits unchanged and does no range check.
- Reset:
  - Asserting rstn aborts any in-flight operation immediately, with no response.
  - mem_we drops asynchronously, so no partial write occurs after reset assertion.
  - Reset values: state IDLE; all outputs 0, including req_ready.

## Timing
Request accepted at cycle T.
- Load: mem_addr valid T+1, mem_dout valid T+2, resp_valid T+3. Next accept ≥ T+4.
- Word store: mem_we T+1, resp_valid T+2. Next accept ≥ T+3.
- Sub-word store: read T+1, merge T+2, mem_we T+3, resp_valid T+4. Next accept ≥ T+5.
- Error (macro on): resp_valid with resp_err = 1 at T+1, with no BRAM access.
- req_ready is low from T+1 until the cycle after RESP.
- Simultaneous req_valid with RESP is not accepted. It is taken in the following IDLE cycle.

## Configuration
Macro `BRAM_ACCESS_MISALIGN_CHECK_EN`.
- Defined:
  - These requests go directly to RESP with resp_err = 1, resp_rdata = 0, and no mem_we:
    - half with addr[0] = 1;
    - word with addr[1:0] ≠ 0;
    - size 11.
- Undefined:
  - resp_err is tied to 0.
  - Misaligned addresses are aligned down (half ignores addr[0]; word ignores addr[1:0]).
  - size 11 is treated as word.

## Test plan
- Word store 0xDEADBEEF to 0x10, then word load 0x10:
  - store resp_valid at T+2;
  - load resp_rdata = 0xDEADBEEF at T+3;
  - mem_addr = 0x10.
- Byte store 0xA5 to 0x13 over word 0x11223344:
  - BRAM word becomes 0xA5223344, with exactly one mem_we cycle at T+3;
  - signed byte load 0x13 returns 0xFFFFFFA5;
  - unsigned byte load returns 0x000000A5.
- Half store 0x8001 to 0x22 over 0:
  - word becomes 0x80010000;
  - signed half load 0x22 returns 0xFFFF8001.
- Load 0x1004 after word store 0xCAFEF00D to 0x4 returns 0xCAFEF00D (4 KiB alias).
- rstn pulsed low during WR of a sub-word store:
  - mem_we = 0 immediately;
  - no resp_valid;
  - req_ready = 1 on the first edge after release.
- With the macro, word load at 0x6 gives resp_err = 1 at T+1 and no BRAM access. Without the macro, it returns the word at 0x4.

Source files
------------

// File: rtl/bram_access_ctrl.sv
// Load/store initiator for the single-port data BRAM: byte/half/word access with sub-word
// stores done as read-modify-write. Optional `BRAM_ACCESS_MISALIGN_CHECK_EN rejects bad requests.
module bram_access_ctrl (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {IDLE, RD, RD_DATA, WR, RESP} state_t;

    // Handshake: a request transfers on the rising edge where req_valid && req_ready;
    // req_ready is registered and only high in IDLE, responses have no backpressure.
    state_t      state;
    logic        op_we;
    logic [1:0]  op_size;
    logic        op_unsigned;
    logic [1:0]  op_lane;
    logic [31:0] op_wdata;
    logic        req_bad;

`ifdef BRAM_ACCESS_MISALIGN_CHECK_EN
    always_comb begin
        req_bad = 1'b0;
        case (req_size)
            2'b01:   req_bad = req_addr[0];
            2'b10:   req_bad = (req_addr[1:0] != 2'b00);
            2'b11:   req_bad = 1'b1;
            default: req_bad = 1'b0;
        endcase
    end
`else
    assign req_bad = 1'b0;
`endif

    assign dbg_state = state;

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic uns, input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   load_extend = {{24{~uns & b[7]}}, b};
            2'b01:   load_extend = {{16{~uns & h[15]}}, h};
            default: load_extend = word;
        endcase
    endfunction

    // Only byte and half stores take the read-modify-write path.
    function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic [31:0] wdata);
        logic [31:0] m;
        m = word;
        if (size == 2'b00)
            m[{lane, 3'b000} +: 8] = wdata[7:0];
        else if (lane[1])
            m[31:16] = wdata[15:0];
        else
            m[15:0] = wdata[15:0];
        return m;
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            req_ready   <= 1'b0;
            resp_valid  <= 1'b0;
            resp_rdata  <= 32'h0;
            resp_err    <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'h0;
            mem_din     <= 32'h0;
            op_we       <= 1'b0;
            op_size     <= 2'b00;
            op_unsigned <= 1'b0;
            op_lane     <= 2'b00;
            op_wdata    <= 32'h0;
        end else begin
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            mem_we     <= 1'b0;
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready   <= 1'b0;
                        op_we       <= req_we;
                        op_size     <= req_size;
                        op_unsigned <= req_unsigned;
                        op_lane     <= req_addr[1:0];
                        op_wdata    <= req_wdata;
                        if (req_bad) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else if (req_we && req_size[1]) begin
                            state    <= WR;
                            mem_addr <= {req_addr[31:2], 2'b00};
                            mem_we   <= 1'b1;
                            mem_din  <= req_wdata;
                        end else begin
                            state    <= RD;
                            mem_addr <= {req_addr[31:2], 2'b00};
                        end
                    end
                end
                RD: state <= RD_DATA;
                RD_DATA: begin
                    if (op_we) begin
                        state   <= WR;
                        mem_we  <= 1'b1;
                        mem_din <= merge_lane(mem_dout, op_size, op_lane, op_wdata);
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= load_extend(mem_dout, op_size, op_unsigned, op_lane);
                    end
                end
                WR: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'h0;
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
